// File: rtl/uart_pkg.sv
// Shared types and default baud constants for the FIFO-fed UART transmitter.
package uart_pkg;

  localparam int CLK_HZ               = 100_000_000;
  localparam int BAUD                 = 115200;
  localparam int DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick pulses on the last rd_clk cycle of each UART bit.
// clear restarts the count so the cycle after it is the first cycle of a bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic rd_clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead FIFO one byte per frame and serialises it LSB first
// with optional even parity and one or two stop bits; tx/busy are registered.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic [15:0]           frame_count
);

  localparam int            BW        = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic [15:0]           fc_q, fc_d;
  logic                  pop;
  logic                  tick;

  // Reset gates the pop so the FIFO never loses a word while we are held.
  assign pop        = (state_q == IDLE) && enable && !fifo_empty && !reset;
  assign fifo_rd_en = pop;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_count = fc_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .rd_clk(rd_clk),
    .reset (reset),
    .clear (pop),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    fc_d    = fc_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d = fifo_rd_data;
          par_d   = ^fifo_rd_data;
          bit_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_d = bit_q + BW'(1);
            tx_d  = shift_d[0];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        // bit_q is reused to count stop bits.
        if (tick) begin
          if (bit_q == LAST_STOP) begin
            busy_d  = 1'b0;
            fc_d    = fc_q + 16'd1;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      fc_q    <= fc_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Three transmitters (8N1, 8E1, 8N2 at 4 clocks/bit) fed by simple FIFO models;
// expected bytes are queued when pushed and checked cycle by cycle on the line.
module tb_fifo_uart_tx;

  logic        rd_clk = 1'b0;
  logic        reset  = 1'b1;
  logic        en     [3];
  logic        empty  [3];
  logic [7:0]  rdd    [3];
  logic        rd_en  [3];
  logic        tx     [3];
  logic        busy   [3];
  logic [15:0] fc     [3];

  logic [7:0]  fmem [3][16];
  int          wp [3] = '{default: 0};
  int          rp [3] = '{default: 0};

  logic [7:0]  sb_q [$];
  int          exp_fc [3] = '{default: 0};
  int          errors = 0;
  int          checks = 0;

  always #5 rd_clk = ~rd_clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign empty[g] = (wp[g] == rp[g]);
    assign rdd[g]   = fmem[g][rp[g][3:0]];
    fifo_uart_tx #(
      .DATA_WIDTH  (8),
      .CLKS_PER_BIT(4),
      .PARITY_EN   ((g == 1) ? 1 : 0),
      .STOP_BITS   ((g == 2) ? 2 : 1)
    ) u_dut (
      .rd_clk      (rd_clk),
      .reset       (reset),
      .enable      (en[g]),
      .fifo_empty  (empty[g]),
      .fifo_rd_data(rdd[g]),
      .fifo_rd_en  (rd_en[g]),
      .tx          (tx[g]),
      .busy        (busy[g]),
      .frame_count (fc[g])
    );
  end

  always @(posedge rd_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_en[i] && !empty[i]) rp[i] <= rp[i] + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    fmem[i][wp[i][3:0]] = b;
    wp[i] = wp[i] + 1;
    sb_q.push_back(b);
  endtask

  function automatic logic tx_exp(input logic [7:0] b, input int par, input int k);
    int n;
    n = (k - 1) / 4;
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
    if (par != 0 && n == 9) return ^b;
    return 1'b1;
  endfunction

  // Starts at a sample point; leaves at the sample point one cycle after the frame.
  task automatic run_frame(input int i, input int max_wait, input int exp_gap,
                           input int drop_at, input int rst_at);
    int         waited;
    int         par;
    int         f;
    logic [7:0] b;
    waited = 0;
    par    = (i == 1) ? 1 : 0;
    f      = (1 + 8 + par + ((i == 2) ? 2 : 1)) * 4;
    while (!rd_en[i] && waited < max_wait) begin
      @(negedge rd_clk);
      waited++;
    end
    chk("pop_seen", rd_en[i], 1'b1);
    if (!rd_en[i]) return;
    if (exp_gap >= 0) chk("pop_gap", waited, exp_gap);
    chk("sb_nonempty", (sb_q.size() > 0), 1'b1);
    if (sb_q.size() == 0) return;
    b = sb_q.pop_front();
    for (int k = 1; k <= f; k++) begin
      @(negedge rd_clk);
      chk($sformatf("tx_d%0d_b%0h_k%0d", i, b, k), tx[i], tx_exp(b, par, k));
      chk("busy_in_frame", busy[i], 1'b1);
      chk("no_pop_in_frame", rd_en[i], 1'b0);
      if (k == drop_at) en[i] = 1'b0;
      if (k == rst_at) begin
        reset = 1'b1;
        #1;
        chk("rst_mid_tx", tx[i], 1'b1);
        chk("rst_mid_busy", busy[i], 1'b0);
        chk("rst_mid_fc", fc[i], 16'd0);
        exp_fc = '{default: 0};
        return;
      end
    end
    @(negedge rd_clk);
    exp_fc[i]++;
    chk("fc_after_frame", fc[i], exp_fc[i]);
    chk("busy_after_frame", busy[i], 1'b0);
    chk("tx_idle_gap", tx[i], 1'b1);
  endtask

  initial begin
    int cnt;
    en = '{default: 1'b0};
    reset = 1'b1;
    repeat (3) @(negedge rd_clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_tx", tx[i], 1'b1);
      chk("rst_rd_en", rd_en[i], 1'b0);
      chk("rst_busy", busy[i], 1'b0);
      chk("rst_fc", fc[i], 16'd0);
    end
    reset = 1'b0;

    // Data waiting but enable low: nothing may be popped.
    push(0, 8'hA5);
    cnt = 0;
    repeat (100) begin
      @(negedge rd_clk);
      if (rd_en[0]) cnt++;
    end
    chk("no_pop_disabled", cnt, 0);
    chk("tx_idle_disabled", tx[0], 1'b1);

    en[0] = 1'b1;
    #1;
    run_frame(0, 2, 0, -1, -1);
    chk("fc_single", fc[0], 16'd1);

    // Back-to-back frames with exactly one idle cycle between them.
    push(0, 8'h01);
    push(0, 8'h80);
    push(0, 8'hFF);
    #1;
    run_frame(0, 2, 0, -1, -1);
    run_frame(0, 0, 0, -1, -1);
    run_frame(0, 0, 0, -1, -1);
    chk("fc_three_more", fc[0], 16'd4);

    // Even parity: 0x07 -> 1, 0x03 -> 0.
    push(1, 8'h07);
    push(1, 8'h03);
    en[1] = 1'b1;
    #1;
    run_frame(1, 2, 0, -1, -1);
    run_frame(1, 0, 0, -1, -1);
    chk("fc_parity", fc[1], 16'd2);

    // Two stop bits, then enable dropped mid-frame with a byte still queued.
    push(2, 8'h00);
    push(2, 8'h5A);
    push(2, 8'hC3);
    en[2] = 1'b1;
    #1;
    run_frame(2, 2, 0, -1, -1);
    run_frame(2, 0, 0, 10, -1);
    cnt = 0;
    repeat (60) begin
      @(negedge rd_clk);
      if (rd_en[2]) cnt++;
    end
    chk("no_pop_after_drop", cnt, 0);
    chk("fc_after_drop", fc[2], 16'd2);
    en[2] = 1'b1;
    #1;
    run_frame(2, 2, 0, -1, -1);

    // Reset in the middle of the data bits; the popped byte is lost.
    push(0, 8'h11);
    push(0, 8'h22);
    #1;
    run_frame(0, 2, 0, -1, 15);
    @(negedge rd_clk);
    chk("rst_hold_rd_en", rd_en[0], 1'b0);
    chk("rst_other_fc1", fc[1], 16'd0);
    chk("rst_other_fc2", fc[2], 16'd0);
    reset = 1'b0;
    #1;
    run_frame(0, 2, 0, -1, -1);
    chk("fc_after_reset", fc[0], 16'd1);
    chk("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
